// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter and its helpers.
package mul_share_pkg;

  localparam int unsigned MUL_OP_W    = 64;
  localparam int unsigned MUL_PROD_W  = 128;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    WAIT,
    RESP
  } mul_arb_state_t;

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester fabric bundle: per-requester operand handshake plus the shared response channel.
interface mul_share_arbiter_if
  import mul_share_pkg::*;
#(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]                req_valid;
  logic [N_REQ-1:0]                req_ready;
  logic [N_REQ-1:0][MUL_OP_W-1:0]  req_a;
  logic [N_REQ-1:0][MUL_OP_W-1:0]  req_b;
  logic                            rsp_valid;
  logic                            rsp_ready;
  logic [ID_W-1:0]                 rsp_id;
  logic [MUL_PROD_W-1:0]           rsp_product;
  logic                            rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product, rsp_err
  );
endinterface

// File: rtl/mul_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr, with wrap.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] id,
  output logic                 any
);
  localparam int unsigned ID_W = $clog2(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int unsigned    ofs;
  int unsigned    sum;

  // Rotate so the slot just after ptr lands at bit 0, then take the lowest set bit.
  always_comb begin
    dbl = {valid, valid} >> (32'(ptr) + 32'd1);
    rot = dbl[N-1:0];
    ofs = 0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (rot[i]) ofs = 32'(i);
    end
    sum = 32'(ptr) + 32'd1 + ofs;
    if (sum >= N) sum = sum - N;
    any   = |valid;
    id    = ID_W'(sum);
    grant = any ? (N'(1) << id) : '0;
  end
endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one multi-cycle multiplier between N_REQ requesters: grant, clear, load, wait, respond.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mul_share_arbiter_if.slave    bus,
  output logic                  mul_reset_n,
  output logic                  mul_w_en,
  output logic [MUL_OP_W-1:0]   mul_a,
  output logic [MUL_OP_W-1:0]   mul_b,
  input  logic                  mul_ok,
  input  logic [MUL_PROD_W-1:0] mul_product
);
  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  mul_arb_state_t        state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d, id_q, id_d, pick_id;
  logic [N_REQ-1:0]      pick_grant;
  logic                  pick_any;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MUL_OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic [MUL_PROD_W-1:0] prod_q, prod_d;
  logic                  err_q, err_d;
  logic                  rsp_valid_q, mul_reset_n_q, mul_w_en_q;

  rr_pick #(
    .N(N_REQ)
  ) u_pick (
    .valid(bus.req_valid),
    .ptr  (ptr_q),
    .grant(pick_grant),
    .id   (pick_id),
    .any  (pick_any)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    prod_d        = prod_q;
    err_d         = err_q;
    bus.req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          bus.req_ready = pick_grant;
          a_d           = bus.req_a[pick_id];
          b_d           = bus.req_b[pick_id];
          id_d          = pick_id;
          ptr_d         = pick_id;
          cnt_d         = '0;
          state_d       = CLR;
        end
      end
      CLR: begin
        if (cnt_q == CLR_LAST) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // cnt_q == 0 is the first WAIT cycle; ok_flag there may be skewed and is ignored.
        if (cnt_q != '0 && mul_ok) begin
          prod_d  = mul_product;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ptr_q         <= ID_W'(N_REQ - 1);
      id_q          <= '0;
      cnt_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      prod_q        <= '0;
      err_q         <= 1'b0;
      rsp_valid_q   <= 1'b0;
      mul_reset_n_q <= 1'b0;
      mul_w_en_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      cnt_q         <= cnt_d;
      a_q           <= a_d;
      b_q           <= b_d;
      prod_q        <= prod_d;
      err_q         <= err_d;
      rsp_valid_q   <= (state_d == RESP);
      mul_reset_n_q <= (state_d != CLR);
      mul_w_en_q    <= (state_d == LOAD);
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_product = prod_q;
  assign bus.rsp_err     = err_q;
  assign mul_reset_n     = mul_reset_n_q;
  assign mul_w_en        = mul_w_en_q;
  assign mul_a           = a_q;
  assign mul_b           = b_q;
endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin scheduler that shares one multi-cycle `multiplier_64bits` instance between `N_REQ` requesters. It accepts operand pairs over per-requester valid/ready, clears and launches the multiplier, waits for `ok_flag` with a watchdog, and returns the 128-bit product tagged with the requester id over one valid/ready response channel. It sits between the requester fabric and the multiplier and owns the multiplier's `reset_n`, `w_en`, `a_in` and `b_in`.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `CLR_CYCLES`, default 2: cycles `mul_reset_n` is held low before each operation.
- `TIMEOUT`, default 255: maximum WAIT cycles before an error response, 1..65535.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in `N_REQ`: per-requester request valid.
- `req_ready` out `N_REQ`: per-requester accept; one-hot or zero.
- `req_a` in `N_REQ`×64: multiplicand per requester.
- `req_b` in `N_REQ`×64: multiplier per requester.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out `$clog2(N_REQ)`: id of the requester that issued the operation.
- `rsp_product` out 128: unsigned product, or 0 on error.
- `rsp_err` out 1: watchdog expired.
- `mul_reset_n` out 1: drives the multiplier's `reset_n`.
- `mul_w_en` out 1: drives the multiplier's `w_en`.
- `mul_a` out 64: drives the multiplier's `a_in`.
- `mul_b` out 64: drives the multiplier's `b_in`.
- `mul_ok` in 1: multiplier `ok_flag`.
- `mul_product` in 128: multiplier `product_out`.

## Operation
- **Reset values:** FSM in IDLE, RR pointer at `N_REQ-1` (so requester 0 has first priority), all outputs 0.
- **FSM states:** IDLE → CLR → LOAD → WAIT → RESP → IDLE.
- **IDLE:**
  - Grant goes to the first requester with `req_valid` set, searching from pointer+1 with wrap.
  - `req_ready[g]` is asserted combinationally for that one cycle only.
  - `req_a`/`req_b` are captured into `mul_a`/`mul_b`, `g` into `rsp_id`, and the pointer is updated to `g`.
  - Next state is CLR. With no valid request, stay in IDLE.
- **CLR:** `mul_reset_n`=0 for `CLR_CYCLES` cycles (counter), then LOAD.
- **LOAD:** `mul_w_en`=1 for exactly one cycle, then WAIT.
- **WAIT:**
  - `mul_ok` is ignored in the first WAIT cycle.
  - From the second WAIT cycle, `mul_ok`=1 captures `mul_product` into `rsp_product` with `rsp_err`=0, then RESP.
  - If the counter reaches `TIMEOUT` first: `rsp_product`=0, `rsp_err`=1, then RESP.
- **RESP:**
  - `rsp_valid`=1. `rsp_id`, `rsp_product` and `rsp_err` are stable until `rsp_valid && rsp_ready`.
  - After the handshake cycle, return to IDLE.
- **Operand hold:** `mul_a`/`mul_b` hold their value from grant until the next grant.
- **Boundary conditions:**
  - Requests arriving outside IDLE are not accepted; `req_ready` stays 0.
  - Simultaneous requests are resolved strictly round-robin. No requester is starved: worst case is `N_REQ-1` operations ahead.
  - A requester that drops `req_valid` before grant is simply skipped.
  - `rsp_ready` held low keeps the block in RESP indefinitely. No new grant occurs.
  - `mul_ok` held high from a previous operation is invalidated by the CLR phase; the first-WAIT-cycle mask covers one-cycle skew.
  - `reset_n` asserted in any state immediately returns everything to reset values. An in-flight operation is discarded with no response.

## Timing
- Acceptance to `mul_w_en`: `CLR_CYCLES`+1 cycles.
- Response latency from grant: `CLR_CYCLES` + 1 + W + 1 cycles, where W = WAIT cycles (≥2).
- Throughput: one operation per (latency + 1) cycles with `rsp_ready`=1 and back-to-back requests.
- All outputs are registered except `req_ready`.

## Structure
- **Package `mul_share_pkg`:**
  - State enum `mul_arb_state_t` {IDLE, CLR, LOAD, WAIT, RESP}.
  - Width constants `MUL_OP_W`=64 and `MUL_PROD_W`=128.
  - `TIMEOUT` default.
- **Sub-module `rr_pick`:** combinational round-robin picker. Inputs are the valid vector and pointer; outputs are the one-hot grant, the encoded id and an any-valid flag. Reused by future shared units.
- **Top-level bench:** instantiates this block plus a real `multiplier_64bits`.

## Test plan
- Single request from id 0, `a`=2000, `b`=5000 → one response, `rsp_id`=0, `rsp_product`=10,000,000, `rsp_err`=0. `mul_reset_n` low for exactly 2 cycles and `mul_w_en` high for exactly 1 cycle.
- All 4 requesters valid simultaneously with `a`=101<<i, `b`=202<<i → grants in order 0,1,2,3, each product 20402<<(2i).
- Operands `a`=`b`=2^64-1 → product 0xFFFF…FFFE_0000…0001 (`rsp_product[127:64]`=64'hFFFFFFFFFFFFFFFE, `rsp_product[63:0]`=64'h1).
- `mul_ok` tied 0 with `TIMEOUT`=8 → `rsp_err`=1 and `rsp_product`=0 after exactly 8 WAIT cycles, then the next request is served normally.
- `rsp_ready` held low for 20 cycles with requester 1 valid → response stable for all 20 cycles, `req_ready` remains 0, then requester 1 is granted after the handshake.
- `reset_n` pulsed low mid-WAIT → all outputs 0 immediately, no response emitted, FSM in IDLE. The next request (101×202) returns 20402.
